// File: rtl/date_entry_pkg.sv
// Shared definitions for the front-panel date setter: FSM states, month
// constants, field codes and the calendar arithmetic helpers.
package date_pkg;

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_EDIT_MONTH = 2'd1,
      ST_EDIT_DAY   = 2'd2,
      ST_COMMIT     = 2'd3
   } state_t;

   typedef logic [1:0] field_t;

   localparam field_t FIELD_NONE  = 2'b00;
   localparam field_t FIELD_MONTH = 2'b01;
   localparam field_t FIELD_DAY   = 2'b10;

   localparam logic [3:0] MONTH_JAN = 4'd1;
   localparam logic [3:0] MONTH_FEB = 4'd2;
   localparam logic [3:0] MONTH_APR = 4'd4;
   localparam logic [3:0] MONTH_JUN = 4'd6;
   localparam logic [3:0] MONTH_SEP = 4'd9;
   localparam logic [3:0] MONTH_NOV = 4'd11;
   localparam logic [3:0] MONTH_DEC = 4'd12;

   localparam logic [7:0] DAY_FIRST = 8'h01;

   // Last day of a non-leap month as packed BCD {tens, units}.
   function automatic logic [7:0] days_in_month(input logic [3:0] month);
      logic [7:0] dim;
      case (month)
         MONTH_FEB: dim = 8'h28;
         MONTH_APR,
         MONTH_JUN,
         MONTH_SEP,
         MONTH_NOV: dim = 8'h30;
         default:   dim = 8'h31;
      endcase
      return dim;
   endfunction

   // Two-digit BCD increment: x9 rolls to (x+1)0.
   function automatic logic [7:0] bcd_inc(input logic [7:0] day);
      logic [7:0] nxt;
      if (day[3:0] == 4'd9) begin
         nxt = {day[7:4] + 4'd1, 4'd0};
      end else begin
         nxt = {day[7:4], day[3:0] + 4'd1};
      end
      return nxt;
   endfunction

   // True when the calendar date is a real non-leap date.
   function automatic logic date_valid(input logic [3:0] month,
                                       input logic [3:0] day10,
                                       input logic [3:0] day1);
      logic ok;
      ok = (month >= MONTH_JAN) && (month <= MONTH_DEC) &&
           (day10 <= 4'd9) && (day1 <= 4'd9) &&
           ({day10, day1} != 8'h00) &&
           ({day10, day1} <= days_in_month(month));
      return ok;
   endfunction

endpackage

// File: rtl/date_entry_if.sv
// Panel-side bus of the date setter: raw keys and switch, the live calendar
// date, and the edited date with its load strobe and edit-status outputs.
interface date_entry_if;
   logic [1:0]      key_n;
   logic            sw_edit;
   logic [3:0]      cur_month;
   logic [3:0]      cur_day10;
   logic [3:0]      cur_day1;
   logic [3:0]      set_month;
   logic [3:0]      set_day10;
   logic [3:0]      set_day1;
   logic            load;
   logic            editing;
   date_pkg::field_t field;
   logic            blink;

   modport master (
      output key_n, sw_edit, cur_month, cur_day10, cur_day1,
      input  set_month, set_day10, set_day1, load, editing, field, blink
   );

   modport slave (
      input  key_n, sw_edit, cur_month, cur_day10, cur_day1,
      output set_month, set_day10, set_day1, load, editing, field, blink
   );
endinterface

// File: rtl/date_entry_key_debounce.sv
// Raw panel input conditioner: 2-flop synchronizer, stable-level debouncer
// and a one-cycle press pulse on the debounced falling edge.
module key_debounce #(
   parameter int   DEBOUNCE_CYCLES = 50000,
   parameter logic IDLE_LEVEL      = 1'b1
) (
   input  logic clock,
   input  logic reset_n,
   input  logic raw,
   output logic level,
   output logic press
);
   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic             sync1_r;
   logic             sync2_r;
   logic             level_r;
   logic             prev_r;
   logic             press_r;
   logic [CNT_W-1:0] cnt_r;

   // Synchronize, count consecutive disagreeing cycles, accept the new level, edge-detect.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         sync1_r <= IDLE_LEVEL;
         sync2_r <= IDLE_LEVEL;
         level_r <= IDLE_LEVEL;
         prev_r  <= IDLE_LEVEL;
         press_r <= 1'b0;
         cnt_r   <= '0;
      end else begin
         sync1_r <= raw;
         sync2_r <= sync1_r;
         prev_r  <= level_r;
         press_r <= prev_r & ~level_r;
         if (sync2_r != level_r) begin
            if (cnt_r == CNT_LAST) begin
               level_r <= sync2_r;
               cnt_r   <= '0;
            end else begin
               cnt_r <= cnt_r + CNT_ONE;
            end
         end else begin
            cnt_r <= '0;
         end
      end
   end

   assign level = level_r;
   assign press = press_r;
endmodule

// File: rtl/date_entry.sv
// Front-panel date setter: debounces the panel controls, runs the month/day
// edit session and presents a validated date with a one-cycle load strobe.
module date_entry
   import date_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int BLINK_CYCLES    = 2500000
) (
   input  logic        clock,
   input  logic        reset_n,
   date_entry_if.slave bus
);
   localparam int BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
   localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);
   localparam logic [BLINK_W-1:0] BLINK_ONE  = BLINK_W'(1);

   logic inc_ev_s, adv_ev_s, sw_level_s;
   logic inc_level_unused_s, adv_level_unused_s, sw_press_unused_s;
   logic sw_prev_r, sw_rise_r;

   state_t     state_r, state_n;
   logic [3:0] month_r, month_n;
   logic [3:0] day10_r, day1_r;
   logic [7:0] day_n, dim_new_s;
   field_t     field_r, field_n;
   logic       load_r, editing_r, blink_r;
   logic [BLINK_W-1:0] blink_cnt_r;

   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .IDLE_LEVEL(1'b1)) u_inc (
      .clock(clock), .reset_n(reset_n), .raw(bus.key_n[0]),
      .level(inc_level_unused_s), .press(inc_ev_s));

   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .IDLE_LEVEL(1'b1)) u_adv (
      .clock(clock), .reset_n(reset_n), .raw(bus.key_n[1]),
      .level(adv_level_unused_s), .press(adv_ev_s));

   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .IDLE_LEVEL(1'b0)) u_sw (
      .clock(clock), .reset_n(reset_n), .raw(bus.sw_edit),
      .level(sw_level_s), .press(sw_press_unused_s));

   // Turn the debounced edit switch into a one-cycle "switch raised" pulse.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         sw_prev_r <= 1'b0;
         sw_rise_r <= 1'b0;
      end else begin
         sw_prev_r <= sw_level_s;
         sw_rise_r <= sw_level_s & ~sw_prev_r;
      end
   end

   // Next-state and next edit values; abort wins, then inc, then adv.
   always_comb begin
      state_n   = state_r;
      month_n   = month_r;
      day_n     = {day10_r, day1_r};
      dim_new_s = days_in_month(month_r);
      case (state_r)
         ST_IDLE: begin
            if (sw_rise_r) begin
               state_n = ST_EDIT_MONTH;
               if (date_valid(bus.cur_month, bus.cur_day10, bus.cur_day1)) begin
                  month_n = bus.cur_month;
                  day_n   = {bus.cur_day10, bus.cur_day1};
               end else begin
                  month_n = MONTH_JAN;
                  day_n   = DAY_FIRST;
               end
            end else begin
               state_n = ST_IDLE;
            end
         end
         ST_EDIT_MONTH: begin
            if (!sw_level_s) begin
               state_n = ST_IDLE;
            end else if (inc_ev_s) begin
               month_n   = (month_r >= MONTH_DEC) ? MONTH_JAN : (month_r + 4'd1);
               dim_new_s = days_in_month(month_n);
               if ({day10_r, day1_r} > dim_new_s) begin
                  day_n = dim_new_s;
               end else begin
                  day_n = {day10_r, day1_r};
               end
            end else if (adv_ev_s) begin
               state_n = ST_EDIT_DAY;
            end else begin
               state_n = ST_EDIT_MONTH;
            end
         end
         ST_EDIT_DAY: begin
            if (!sw_level_s) begin
               state_n = ST_IDLE;
            end else if (inc_ev_s) begin
               if ({day10_r, day1_r} >= dim_new_s) begin
                  day_n = DAY_FIRST;
               end else begin
                  day_n = bcd_inc({day10_r, day1_r});
               end
            end else if (adv_ev_s) begin
               state_n = ST_COMMIT;
            end else begin
               state_n = ST_EDIT_DAY;
            end
         end
         ST_COMMIT: state_n = ST_IDLE;
         default:   state_n = ST_IDLE;
      endcase
   end

   // Field indicator follows the state being entered.
   always_comb begin
      field_n = FIELD_NONE;
      case (state_n)
         ST_EDIT_MONTH: field_n = FIELD_MONTH;
         ST_EDIT_DAY:   field_n = FIELD_DAY;
         default:       field_n = FIELD_NONE;
      endcase
   end

   // State register and registered date/status outputs.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_r   <= ST_IDLE;
         month_r   <= MONTH_JAN;
         day10_r   <= 4'd0;
         day1_r    <= 4'd1;
         load_r    <= 1'b0;
         editing_r <= 1'b0;
         field_r   <= FIELD_NONE;
      end else begin
         state_r   <= state_n;
         month_r   <= month_n;
         day10_r   <= day_n[7:4];
         day1_r    <= day_n[3:0];
         load_r    <= (state_n == ST_COMMIT);
         editing_r <= (state_n != ST_IDLE);
         field_r   <= field_n;
      end
   end

   // Blink runs only across consecutive editing cycles and drops to 0 on exit.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         blink_cnt_r <= '0;
         blink_r     <= 1'b0;
      end else if ((state_n != ST_IDLE) && (state_r != ST_IDLE)) begin
         if (blink_cnt_r == BLINK_LAST) begin
            blink_cnt_r <= '0;
            blink_r     <= ~blink_r;
         end else begin
            blink_cnt_r <= blink_cnt_r + BLINK_ONE;
         end
      end else begin
         blink_cnt_r <= '0;
         blink_r     <= 1'b0;
      end
   end

   assign bus.set_month = month_r;
   assign bus.set_day10 = day10_r;
   assign bus.set_day1  = day1_r;
   assign bus.load      = load_r;
   assign bus.editing   = editing_r;
   assign bus.field     = field_r;
   assign bus.blink     = blink_r;
endmodule

// File: tb/tb_date_entry.sv
// Bench for date_entry: a calendar-level model (integer dates, debounce as a
// stable-sample window plus fixed latency) checked every cycle, plus
// hand-computed literal checks on the directed scenarios.
module tb_date_entry;
   localparam int D = 4;
   localparam int B = 8;

   logic clock = 1'b0;
   logic reset_n;
   date_entry_if bus();

   date_entry #(.DEBOUNCE_CYCLES(D), .BLINK_CYCLES(B)) dut (
      .clock(clock), .reset_n(reset_n), .bus(bus));

   always #5 clock = ~clock;

   int n_cmp = 0;
   int n_bad = 0;
   int load_pulses = 0;
   bit chk_en = 1'b0;

   // ---------------- model ----------------
   localparam int M_IDLE = 0, M_EM = 1, M_ED = 2, M_CM = 3;
   int m_st, m_month, m_day, cyc, entry_cyc;
   bit m_load;
   bit hist[3][D+1];
   bit lvl[3];
   bit moved_d1[3], moved_d2[3];
   bit idle_lvl[3] = '{1'b1, 1'b1, 1'b0};

   function automatic int dim(input int m);
      if (m == 2) return 28;
      if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
      return 31;
   endfunction

   always @(posedge clock) begin
      bit raw[3];
      bit ev_inc, ev_adv, sw_rise, sw_lvl, same, v;
      int cm, cd;
      raw[0] = bus.key_n[0];
      raw[1] = bus.key_n[1];
      raw[2] = bus.sw_edit;
      cyc++;
      if (!reset_n) begin
         chk_en = 1'b1;
         m_st = M_IDLE; m_month = 1; m_day = 1; m_load = 1'b0;
         for (int i = 0; i < 3; i++) begin
            lvl[i] = idle_lvl[i]; moved_d1[i] = 1'b0; moved_d2[i] = 1'b0;
            for (int k = 0; k <= D; k++) hist[i][k] = idle_lvl[i];
         end
      end else begin
         ev_inc  = moved_d2[0];
         ev_adv  = moved_d2[1];
         sw_rise = moved_d2[2];
         sw_lvl  = lvl[2];
         m_load  = 1'b0;
         case (m_st)
            M_IDLE: if (sw_rise) begin
               m_st = M_EM; entry_cyc = cyc;
               cm = int'(bus.cur_month);
               cd = 10 * int'(bus.cur_day10) + int'(bus.cur_day1);
               if (cm >= 1 && cm <= 12 && bus.cur_day1 <= 9 && bus.cur_day10 <= 9 &&
                   cd >= 1 && cd <= dim(cm)) begin
                  m_month = cm; m_day = cd;
               end else begin
                  m_month = 1; m_day = 1;
               end
            end
            M_EM: if (!sw_lvl) m_st = M_IDLE;
                  else if (ev_inc) begin
                     m_month = m_month % 12 + 1;
                     if (m_day > dim(m_month)) m_day = dim(m_month);
                  end else if (ev_adv) m_st = M_ED;
            M_ED: if (!sw_lvl) m_st = M_IDLE;
                  else if (ev_inc) m_day = m_day % dim(m_month) + 1;
                  else if (ev_adv) begin m_st = M_CM; m_load = 1'b1; end
            default: m_st = M_IDLE;
         endcase
         // debounced level moves once D consecutive samples (2 synchronizer cycles old) agree
         for (int i = 0; i < 3; i++) begin
            moved_d2[i] = moved_d1[i];
            moved_d1[i] = 1'b0;
            v = hist[i][1];
            same = 1'b1;
            for (int k = 1; k <= D; k++) if (hist[i][k] != v) same = 1'b0;
            if (same && v != lvl[i]) begin
               lvl[i] = v;
               moved_d1[i] = (v != idle_lvl[i]);
            end
            for (int k = D; k > 0; k--) hist[i][k] = hist[i][k-1];
            hist[i][0] = raw[i];
         end
      end
   end

   // ---------------- every-cycle compare ----------------
   always @(negedge clock) begin
      logic [16:0] got, exp;
      bit ed;
      int bl;
      if (chk_en) begin
         ed = (m_st != M_IDLE);
         bl = ed ? (((cyc - entry_cyc) / B) % 2) : 0;
         got = {bus.set_month, bus.set_day10, bus.set_day1, bus.load, bus.editing, bus.field, bus.blink};
         exp = {4'(m_month), 4'(m_day / 10), 4'(m_day % 10), m_load, ed,
                (m_st == M_EM) ? 2'b01 : ((m_st == M_ED) ? 2'b10 : 2'b00), bl[0]};
         n_cmp++;
         if (got !== exp) begin
            n_bad++;
            $display("FAIL cycle_model t=%0t: got m=%0d d=%0h%0h ld=%b ed=%b f=%b bl=%b, expected %h",
                     $time, got[16:13], got[12:9], got[8:5], got[4], got[3], got[2:1], got[0], exp);
         end
         if (bus.load === 1'b1) load_pulses++;
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic press(input int idx);
      bus.key_n[idx] = 1'b0; tick(10);
      bus.key_n[idx] = 1'b1; tick(12);
   endtask

   task automatic set_cur(input int m, input int d10, input int d1);
      bus.cur_month = 4'(m); bus.cur_day10 = 4'(d10); bus.cur_day1 = 4'(d1);
   endtask

   task automatic chk_date(input string name, input int m, input int d10, input int d1);
      chk({name, "_month"}, int'(bus.set_month), m);
      chk({name, "_day10"}, int'(bus.set_day10), d10);
      chk({name, "_day1"},  int'(bus.set_day1), d1);
   endtask

   initial begin
      reset_n = 1'b0; bus.key_n = 2'b11; bus.sw_edit = 1'b0; set_cur(0, 0, 0);
      tick(3);
      chk_date("rst", 1, 0, 1);
      chk("rst_load", int'(bus.load), 0);
      chk("rst_editing", int'(bus.editing), 0);
      chk("rst_field", int'(bus.field), 0);
      chk("rst_blink", int'(bus.blink), 0);
      reset_n = 1'b1; tick(2);

      // entry 12/31
      set_cur(12, 3, 1); bus.sw_edit = 1'b1; tick(12);
      chk_date("entry", 12, 3, 1);
      chk("entry_field", int'(bus.field), 1);
      chk("model_entry_day", m_day, 31);

      // bounce: 2-cycle glitch, then stable low; inc lands 8 edges after stable drive
      bus.key_n[0] = 1'b0; tick(2); bus.key_n[0] = 1'b1; tick(2);
      bus.key_n[0] = 1'b0; tick(7);
      chk("bounce_before_event", int'(bus.set_month), 12);
      tick(1);
      chk_date("bounce_wrap", 1, 3, 1);
      tick(2); bus.key_n[0] = 1'b1; tick(12);
      chk("bounce_single_event", int'(bus.set_month), 1);

      press(0);
      chk_date("clamp_feb", 2, 2, 8);
      chk("model_feb_day", m_day, 28);
      press(1);
      chk("field_day", int'(bus.field), 2);
      press(0);
      chk_date("day_wrap", 2, 0, 1);

      // commit
      bus.key_n[1] = 1'b0; tick(8);
      chk("commit_load", int'(bus.load), 1);
      chk_date("commit", 2, 0, 1);
      tick(1);
      chk("commit_load_end", int'(bus.load), 0);
      chk("commit_editing_end", int'(bus.editing), 0);
      bus.key_n[1] = 1'b1; tick(12);
      press(0);
      chk("idle_inc_ignored", int'(bus.set_month), 2);

      // new session: clamp 3/31 -> 4/30, then simultaneous inc+adv
      bus.sw_edit = 1'b0; tick(12);
      set_cur(3, 3, 1); bus.sw_edit = 1'b1; tick(12);
      chk_date("entry_mar", 3, 3, 1);
      press(0);
      chk_date("clamp_apr", 4, 3, 0);
      bus.key_n = 2'b00; tick(10); bus.key_n = 2'b11; tick(12);
      chk_date("simul", 5, 3, 0);
      chk("simul_field", int'(bus.field), 1);

      // abort from EDIT_DAY
      press(1);
      chk("abort_pre_field", int'(bus.field), 2);
      tick(10);
      bus.sw_edit = 1'b0; tick(12);
      chk("abort_editing", int'(bus.editing), 0);
      chk("abort_field", int'(bus.field), 0);
      chk("abort_blink", int'(bus.blink), 0);
      chk_date("abort_keep", 5, 3, 0);

      // reset mid-session
      set_cur(7, 1, 5); bus.sw_edit = 1'b1; tick(12);
      press(0); tick(5);
      chk_date("pre_reset", 8, 1, 5);
      reset_n = 1'b0; bus.sw_edit = 1'b0; tick(1);
      chk_date("mid_reset", 1, 0, 1);
      chk("mid_reset_editing", int'(bus.editing), 0);
      chk("mid_reset_blink", int'(bus.blink), 0);
      reset_n = 1'b1; tick(2);

      // invalid calendar date on entry
      set_cur(2, 3, 0); bus.sw_edit = 1'b1; tick(12);
      chk_date("invalid_entry", 1, 0, 1);
      bus.sw_edit = 1'b0; tick(12);

      chk("load_pulse_count", load_pulses, 1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
